// File: rtl/dram_addr_mapper.sv
// Registered DRAM address mapper: decodes bank/row/col, tracks open rows per bank, 2-entry output FIFO.
// Optional macro BANK_XOR_HASH_EN: bank_id = decoded bank XOR low row bits (tracker uses hashed bank).
module dram_addr_mapper #(
  parameter int ADDR_WIDTH   = 13,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  map_mode,
  input  logic                  l2_req_valid,
  output logic                  l2_req_ready,
  input  logic [ADDR_WIDTH-1:0] l2_req_address,
  input  logic                  l2_req_write,
  input  logic                  bank_close_valid,
  input  logic [BW-1:0]         bank_close_id,
  input  logic                  flush,
  output logic                  dram_req_valid,
  input  logic                  dram_req_ready,
  output logic [BW-1:0]         bank_id,
  output logic [RW-1:0]         row_id,
  output logic [CW-1:0]         col_id,
  output logic                  req_write,
  output logic [1:0]            row_state
);

  typedef enum logic [1:0] {
    RS_CLOSED   = 2'b00,
    RS_HIT      = 2'b01,
    RS_CONFLICT = 2'b10
  } row_state_e;

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          wr;
    row_state_e    rs;
  } entry_t;

  logic [1:0]              count_q, count_d, count_after_pop;
  entry_t                  slot0_q, slot0_d, slot1_q, slot1_d, new_entry;
  logic [NUM_OF_BANKS-1:0] open_valid_q, open_valid_d, eff_valid;
  logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
  logic [BW-1:0]           dec_bank, req_bank;
  logic [RW-1:0]           dec_row;
  logic [CW-1:0]           dec_col;
  logic                    accept, pop;
  row_state_e              cls;

  assign l2_req_ready   = (count_q < 2'd2);
  assign dram_req_valid = (count_q != 2'd0);
  assign accept         = l2_req_valid && l2_req_ready;
  assign pop            = dram_req_valid && dram_req_ready;

  always_comb begin
    dec_col = l2_req_address[CW-1:0];
    if (!map_mode) begin
      dec_bank = l2_req_address[ADDR_WIDTH-1 -: BW];
      dec_row  = l2_req_address[ADDR_WIDTH-BW-1 -: RW];
    end else begin
      dec_row  = l2_req_address[ADDR_WIDTH-1 -: RW];
      dec_bank = l2_req_address[CW +: BW];
    end
  end

`ifdef BANK_XOR_HASH_EN
  assign req_bank = dec_bank ^ dec_row[BW-1:0];
`else
  assign req_bank = dec_bank;
`endif

  // Close/flush of this cycle is applied before the incoming request is classified.
  always_comb begin
    eff_valid = flush ? '0 : open_valid_q;
    if (bank_close_valid) eff_valid[bank_close_id] = 1'b0;
    if (!eff_valid[req_bank])               cls = RS_CLOSED;
    else if (open_row_q[req_bank] == dec_row) cls = RS_HIT;
    else                                    cls = RS_CONFLICT;
    open_valid_d = eff_valid;
    if (accept) open_valid_d[req_bank] = 1'b1;
  end

  always_comb begin
    new_entry       = '{bank: req_bank, row: dec_row, col: dec_col,
                        wr: l2_req_write, rs: cls};
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;
    count_after_pop = count_q - {1'b0, pop};
    count_d         = count_after_pop + {1'b0, accept};
    if (pop) slot0_d = slot1_q;
    if (accept) begin
      if (count_after_pop == 2'd0) slot0_d = new_entry;
      else                         slot1_d = new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      open_valid_q <= '0;
    end else begin
      count_q      <= count_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      open_valid_q <= open_valid_d;
    end
  end

  // Open rows are only meaningful while the matching open_valid bit is set.
  always_ff @(posedge clk) begin
    if (accept) open_row_q[req_bank] <= dec_row;
  end

  assign bank_id   = slot0_q.bank;
  assign row_id    = slot0_q.row;
  assign col_id    = slot0_q.col;
  assign req_write = slot0_q.wr;
  assign row_state = slot0_q.rs;

endmodule

// File: tb/tb_dram_addr_mapper.sv
// Self-checking bench for dram_addr_mapper: vector table, directed corner sequences, random vs reference model.
module tb_dram_addr_mapper;

  localparam int NB = 8, NR = 128, NC = 8;

  logic        clk = 1'b0;
  logic        rst_n, map_mode, l2_req_valid, l2_req_ready, l2_req_write;
  logic [12:0] l2_req_address;
  logic        bank_close_valid, flush, dram_req_valid, dram_req_ready;
  logic [2:0]  bank_close_id, bank_id, col_id;
  logic [6:0]  row_id;
  logic        req_write;
  logic [1:0]  row_state;

  int total = 0;
  int bad   = 0;

  dram_addr_mapper dut (
    .clk(clk), .rst_n(rst_n), .map_mode(map_mode),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_address(l2_req_address), .l2_req_write(l2_req_write),
    .bank_close_valid(bank_close_valid), .bank_close_id(bank_close_id), .flush(flush),
    .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
    .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .req_write(req_write), .row_state(row_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    logic [12:0] addr;
    int          wr;
    int          bank;
    int          row;
    int          col;
    int          rs;
    int          rs_h;
  } vec_t;

  typedef struct {
    int bank, row, col, wr, rs;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int b, input int r, input int c, input int w, input int rs);
    pk = 32'(((b & 7) << 13) | ((r & 127) << 6) | ((c & 7) << 3) | ((w & 1) << 2) | (rs & 3));
  endfunction

  function automatic logic [31:0] dut_word();
    dut_word = 32'({bank_id, row_id, col_id, req_write, row_state});
  endfunction

  function automatic void decode(input bit mode, input int addr, output int b, output int r, output int c);
    c = addr % NC;
    if (!mode) begin
      b = addr / (NR * NC);
      r = (addr / NC) % NR;
    end else begin
      r = addr / (NB * NC);
      b = (addr / NC) % NB;
    end
`ifdef BANK_XOR_HASH_EN
    b = b ^ (r % NB);
`endif
  endfunction

  task automatic idle_inputs();
    map_mode = 1'b0; l2_req_valid = 1'b0; l2_req_address = '0; l2_req_write = 1'b0;
    bank_close_valid = 1'b0; bank_close_id = '0; flush = 1'b0; dram_req_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    bit   ov[NB];
    int   orow[NB];
    ent_t q[$];
    ent_t e;
    bit   acc, pp;
    for (int i = 0; i < NB; i++) begin ov[i] = 0; orow[i] = 0; end
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      chk("rnd_l2_ready", 32'(l2_req_ready), 32'(q.size() < 2));
      chk("rnd_dram_valid", 32'(dram_req_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("rnd_head", dut_word(), pk(q[0].bank, q[0].row, q[0].col, q[0].wr, q[0].rs));
      l2_req_valid     = ($urandom_range(0, 3) != 0);
      map_mode         = 1'($urandom_range(0, 1));
      l2_req_address   = 13'($urandom_range(0, 8191));
      l2_req_write     = 1'($urandom_range(0, 1));
      dram_req_ready   = ($urandom_range(0, 3) != 0);
      bank_close_valid = ($urandom_range(0, 5) == 0);
      bank_close_id    = 3'($urandom_range(0, NB - 1));
      flush            = ($urandom_range(0, 40) == 0);
      acc = l2_req_valid && (q.size() < 2);
      pp  = dram_req_ready && (q.size() > 0);
      if (flush) for (int i = 0; i < NB; i++) ov[i] = 0;
      if (bank_close_valid) ov[int'(bank_close_id)] = 0;
      if (pp) void'(q.pop_front());
      if (acc) begin
        decode(map_mode, int'(l2_req_address), e.bank, e.row, e.col);
        e.wr = int'(l2_req_write);
        e.rs = !ov[e.bank] ? 0 : (orow[e.bank] == e.row ? 1 : 2);
        ov[e.bank] = 1; orow[e.bank] = e.row;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    vec_t vt[5];
    int   b, r, c, eb;
    int   ea[3], eb3[3], er[3], ec[3];
    logic [12:0] bp_addr[3];

    vt[0] = '{mode: 0, addr: 13'h1C0B, wr: 1, bank: 7, row: 1,    col: 3, rs: 0, rs_h: 0};
    vt[1] = '{mode: 1, addr: 13'h1C0B, wr: 0, bank: 1, row: 'h70, col: 3, rs: 0, rs_h: 0};
    vt[2] = '{mode: 0, addr: 13'h0008, wr: 0, bank: 0, row: 1,    col: 0, rs: 0, rs_h: 2};
    vt[3] = '{mode: 0, addr: 13'h000F, wr: 1, bank: 0, row: 1,    col: 7, rs: 1, rs_h: 1};
    vt[4] = '{mode: 0, addr: 13'h0010, wr: 0, bank: 0, row: 2,    col: 0, rs: 2, rs_h: 0};

    do_reset();
    chk("reset_dram_valid", 32'(dram_req_valid), 32'd0);
    chk("reset_l2_ready", 32'(l2_req_ready), 32'd1);
    chk("reset_outputs", dut_word(), 32'd0);

    // vector table: one request at a time, scheduler always ready
    eb = 0;
    for (int i = 0; i < 5; i++) begin
      map_mode = vt[i].mode; l2_req_address = vt[i].addr; l2_req_write = 1'(vt[i].wr);
      l2_req_valid = 1'b1;
      @(negedge clk);
      l2_req_valid = 1'b0;
      chk("vec_dram_valid", 32'(dram_req_valid), 32'd1);
`ifdef BANK_XOR_HASH_EN
      eb = vt[i].bank ^ (vt[i].row % NB);
      chk("vec_fields", dut_word(), pk(eb, vt[i].row, vt[i].col, vt[i].wr, vt[i].rs_h));
`else
      eb = vt[i].bank;
      chk("vec_fields", dut_word(), pk(eb, vt[i].row, vt[i].col, vt[i].wr, vt[i].rs));
`endif
    end

    // precharge the bank just used, then re-send the same address
    bank_close_valid = 1'b1; bank_close_id = 3'(eb);
    @(negedge clk);
    bank_close_valid = 1'b0;
    map_mode = 1'b0; l2_req_address = 13'h0010; l2_req_valid = 1'b1;
    @(negedge clk);
    l2_req_valid = 1'b0;
    chk("reopen_after_close", 32'(row_state), 32'd0);

    // backpressure: three back-to-back requests with scheduler stalled
    bp_addr[0] = 13'h0123; bp_addr[1] = 13'h1456; bp_addr[2] = 13'h0ABC;
    for (int i = 0; i < 3; i++) begin
      decode(1'b0, int'(bp_addr[i]), b, r, c);
      eb3[i] = b; er[i] = r; ec[i] = c;
      ea[i] = (b << 10) | (r << 3) | c;
    end
    @(negedge clk);
    dram_req_ready = 1'b0; map_mode = 1'b0;
    l2_req_valid = 1'b1; l2_req_address = bp_addr[0];
    @(negedge clk);
    chk("bp_ready_after_1", 32'(l2_req_ready), 32'd1);
    l2_req_address = bp_addr[1];
    @(negedge clk);
    chk("bp_ready_after_2", 32'(l2_req_ready), 32'd0);
    l2_req_address = bp_addr[2];
    @(negedge clk);
    chk("bp_ready_held", 32'(l2_req_ready), 32'd0);
    chk("bp_head_stable", 32'({bank_id, row_id, col_id}), 32'(ea[0]));
    dram_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_out1", 32'({bank_id, row_id, col_id}), 32'(ea[1]));
    @(negedge clk);
    l2_req_valid = 1'b0;
    chk("bp_out2_valid", 32'(dram_req_valid), 32'd1);
    chk("bp_out2", 32'({bank_id, row_id, col_id}), 32'(ea[2]));
    @(negedge clk);
    chk("bp_drained", 32'(dram_req_valid), 32'd0);

    // asynchronous reset with two buffered entries
    dram_req_ready = 1'b0; l2_req_valid = 1'b1; l2_req_address = 13'h1FFF;
    repeat (2) @(negedge clk);
    l2_req_valid = 1'b0;
    chk("pre_rst_full", 32'(l2_req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(dram_req_valid), 32'd0);
    chk("rst_mid_ready", 32'(l2_req_ready), 32'd1);
    chk("rst_mid_outputs", dut_word(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dram_req_ready = 1'b1;
    map_mode = 1'b0; l2_req_address = 13'h0008; l2_req_write = 1'b0; l2_req_valid = 1'b1;
    @(negedge clk);
    l2_req_valid = 1'b0;
    chk("post_rst_valid", 32'(dram_req_valid), 32'd1);
    chk("post_rst_closed", 32'(row_state), 32'd0);

    // randomized traffic against the reference model
    do_reset();
    rand_phase(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
